// File: rtl/mm_pkg.sv
// Width helpers shared across the matrix-multiply engine so stage widths agree.
package mm_pkg;

  // Accumulator width able to hold terms * (2^in_w - 1) without overflow.
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned terms);
    return in_w + $clog2(terms);
  endfunction

  // Counter width able to represent 0..terms inclusive.
  function automatic int unsigned cnt_width(input int unsigned terms);
    return $clog2(terms + 1);
  endfunction

endpackage

// File: rtl/dot_accumulator.sv
// Accumulates a stream of unsigned partial sums into one dot-product result per vector.
module dot_accumulator
  import mm_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 11,
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic                                  Clock,
  input  logic                                  Reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [IN_WIDTH-1:0]                   in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [acc_width(IN_WIDTH, MAX_TERMS)-1:0] out_data,
  output logic [cnt_width(MAX_TERMS)-1:0]       out_count,
  output logic                                  err_overrun
);

  localparam int unsigned ACC_WIDTH = acc_width(IN_WIDTH, MAX_TERMS);
  localparam int unsigned CNT_WIDTH = cnt_width(MAX_TERMS);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 closing;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Result register frees up when empty or being drained this cycle.
  assign in_ready = ~out_valid_q | out_ready;

  // Next-state for the accumulator, output and error register groups.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    accept   = in_valid & in_ready;
    closing  = in_last | (cnt_q == CNT_WIDTH'(MAX_TERMS - 1));
    acc_base = (cnt_q == '0) ? '0 : acc_q;
    sum      = acc_base + ACC_WIDTH'(in_data);
    cnt_inc  = cnt_q + CNT_WIDTH'(1);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (closing) begin
        out_data_d  = sum;
        out_count_d = cnt_inc;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        if (!in_last) begin
          err_d = 1'b1;
        end
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_count   = out_count_q;
  assign err_overrun = err_q;

endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

Sequential accumulation stage directly downstream of `noOverflowAdd` in the matrix-multiply datapath. It consumes a stream of unsigned partial sums, one per handshake, and accumulates each row×column vector into a width-grown register. It emits one registered dot-product result per vector, together with its term count. Output width is sized so that no overflow is possible for up to MAX_TERMS terms.

## Interface
Parameters:
- IN_WIDTH, 11: width of incoming partial sums; matches the adder's RES_WIDTH.
- MAX_TERMS, 16: maximum terms per vector; must be ≥ 2.
- ACC_WIDTH, IN_WIDTH + $clog2(MAX_TERMS): result width (localparam, derived, not overridable).
- CNT_WIDTH, $clog2(MAX_TERMS+1): term-count width (localparam).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data/in_last are valid this cycle.
- in_ready  out  1  block accepts a term this cycle.
- in_data  in  IN_WIDTH  unsigned partial sum.
- in_last  in  1  marks the final term of the current vector.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_WIDTH  completed dot product.
- out_count  out  CNT_WIDTH  number of terms in out_data.
- err_overrun  out  1  sticky; a vector hit MAX_TERMS without in_last.

## Operation
- Term accept: a term is accepted when in_valid && in_ready.
- Accumulator registers: acc (ACC_WIDTH) and cnt (CNT_WIDTH). A vector is "open" when cnt ≠ 0.
- Non-closing accept: acc <= acc + in_data, zero-extended. If cnt == 0, acc loads in_data instead. cnt <= cnt + 1.
- Closing accept: a term closes the vector if in_last = 1, or if cnt == MAX_TERMS−1.
  - out_data <= acc + in_data (or in_data if cnt == 0).
  - out_count <= cnt + 1.
  - out_valid <= 1.
  - acc <= 0 and cnt <= 0.
- Forced close: a close caused by the count limit with in_last = 0 sets err_overrun. The next term then starts a new vector.
- Flow control: in_ready = ~out_valid | out_ready. This holds regardless of whether a vector is open.
- Output handshake: out_valid clears on out_valid && out_ready, unless a new closing term is accepted in the same cycle. In that case out_valid stays 1 and the output registers load the new result.
- Output stability: out_data and out_count are stable while out_valid && !out_ready.
- Arithmetic: unsigned only. The maximum value MAX_TERMS·(2^IN_WIDTH−1) fits in ACC_WIDTH, so no saturation or wrap logic is needed.
- Error flag: err_overrun clears only on reset.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_count = 0, err_overrun = 0, acc = 0, cnt = 0. in_ready = 1 after reset.
- Latency: the result is visible with out_valid = 1 on the cycle after the closing term is accepted.
- Throughput: one term per cycle sustained when out_ready = 1. Back-to-back single-term vectors produce one result per cycle.
- Backpressure: in_ready is combinational from out_valid and out_ready only. It never depends on in_valid or in_last.
- Reset mid-vector: the partial accumulation is discarded. Any pending result is dropped; no result is emitted.

## Structure
- Shared package `mm_pkg`: ACC_WIDTH/CNT_WIDTH derivation functions, so the multiplier, adder, and accumulator widths agree across the engine.
- No sub-module is needed; it is a single module with three registers groups (acc/cnt, output, error).
- Optional wrapper: a `dot_accumulator` instance fed directly from `noOverflowAdd.sum`, for integration tests.

## Test plan
- Basic vector: terms 3, 5, 7, 9 with in_last on 9, out_ready = 1 → one cycle later out_data = 24, out_count = 4, out_valid high for exactly one cycle.
- Worst case: 16 terms of 2047 with in_last on the 16th → out_data = 32752, out_count = 16, err_overrun = 0.
- Overrun: 20 terms of 1 with no in_last → first result = 16 with out_count = 16 and err_overrun = 1. Later in_last on the 20th term → second result = 4, out_count = 4.
- Backpressure: result pending with out_ready = 0 for 5 cycles → in_ready = 0, and out_data/out_count are held constant. On out_ready = 1 the next term is accepted in the same cycle.
- Back-to-back: single-term vectors 100, 200, 300 on consecutive cycles, each with in_last, out_ready = 1 → outputs 100, 200, 300 on consecutive cycles, each with out_count = 1.
- Reset mid-vector: accept 10 and 20, assert Reset_n = 0 for one cycle, then send 7 with in_last → out_data = 7, out_count = 1.
